elastic_pipeline: RTL and testbench

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

---
 rtl/elastic_pipeline.sv | 76 +++++++
 tb/tb_elastic_pipeline.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH cascaded valid/ready stages, either 2-entry skid buffers
// with registered ready or 1-entry pass-through registers, with an occupancy count.
module elastic_pipeline #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int REG_READY = 1,
  localparam int CAP = DEPTH * ((REG_READY != 0) ? 2 : 1),
  localparam int OCC_W = $clog2(CAP + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]      occupancy
);
  logic                  v [DEPTH+1];
  logic                  r [DEPTH+1];
  logic [DATA_WIDTH-1:0] d [DEPTH+1];
  assign v[0] = in_valid & ~flush;
  assign d[0] = in_data;
  assign r[DEPTH] = out_ready & ~flush;
  assign in_ready = r[0] & ~flush;
  assign out_valid = v[DEPTH] & ~flush;
  assign out_data = d[DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (REG_READY != 0) begin : g_skid
      logic                  mv, sv;
      logic [DATA_WIDTH-1:0] md, sd;
      assign r[k] = ~sv;
      assign v[k+1] = mv;
      assign d[k+1] = md;
      // Main entry refills from skid before taking new input, keeping order.
      always_ff @(posedge clk)
        if (rst) begin
          mv <= 1'b0;
          sv <= 1'b0;
          md <= '0;
          sd <= '0;
        end else if (flush) begin
          mv <= 1'b0;
          sv <= 1'b0;
        end else if (!mv || r[k+1]) begin
          mv <= sv | v[k];
          sv <= 1'b0;
          if (sv) md <= sd;
          else if (v[k]) md <= d[k];
        end else if (v[k] && !sv) begin
          sv <= 1'b1;
          sd <= d[k];
        end
    end else begin : g_pass
      logic                  rv;
      logic [DATA_WIDTH-1:0] rd;
      assign r[k] = ~rv | r[k+1];
      assign v[k+1] = rv;
      assign d[k+1] = rd;
      always_ff @(posedge clk)
        if (rst) begin
          rv <= 1'b0;
          rd <= '0;
        end else if (flush) rv <= 1'b0;
        else if (r[k]) begin
          rv <= v[k];
          if (v[k]) rd <= d[k];
        end
    end
  end
  always_ff @(posedge clk)
    occupancy <= (rst || flush) ? '0
               : occupancy + OCC_W'(in_valid && in_ready) - OCC_W'(out_valid && out_ready);
endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed vector table on a skid-buffer pipeline, hand sequences
// for pass-through, reset and flush corners, and a random scoreboard run on both variants.
module tb_elastic_pipeline;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f1 = 1'b0, iv1 = 1'b0, or1 = 1'b0, ir1, ov1;
  logic [7:0] id1 = '0, od1;
  logic [2:0] oc1;
  logic       f0 = 1'b0, iv0 = 1'b0, or0 = 1'b0, ir0, ov0;
  logic [7:0] id0 = '0, od0;
  logic [1:0] oc0;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  elastic_pipeline #(.DATA_WIDTH(8), .DEPTH(2), .REG_READY(1)) u1 (
    .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1));
  elastic_pipeline #(.DATA_WIDTH(8), .DEPTH(2), .REG_READY(0)) u0 (
    .clk(clk), .rst(rst), .flush(f0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(oc0));

  typedef struct {
    logic       fl, iv;
    logic [7:0] id;
    logic       ordy, ir, ov;
    logic [7:0] od;
    logic [2:0] oc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic fl, logic iv, logic [7:0] id, logic ordy,
                              logic ir, logic ov, logic [7:0] od, logic [2:0] oc);
    vec_t x;
    x.fl = fl; x.iv = iv; x.id = id; x.ordy = ordy;
    x.ir = ir; x.ov = ov; x.od = od; x.oc = oc;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q1[$], q0[$];
  int acc1, acc0, del1, del0, cyc;
  bit got;

  initial begin
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h11, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h22, 1, 1, 0, 8'h00, 1));
    tbl.push_back(mk(0, 1, 8'h33, 1, 1, 1, 8'h11, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h22, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h33, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h33, 0));
    tbl.push_back(mk(0, 1, 8'hA0, 0, 1, 0, 8'h33, 0));
    tbl.push_back(mk(0, 1, 8'hA1, 0, 1, 0, 8'h33, 1));
    tbl.push_back(mk(0, 1, 8'hA2, 0, 1, 1, 8'hA0, 2));
    tbl.push_back(mk(0, 1, 8'hA3, 0, 1, 1, 8'hA0, 3));
    tbl.push_back(mk(0, 1, 8'hA4, 0, 0, 1, 8'hA0, 4));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 1, 8'hA0, 4));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'hA0, 4));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'hA1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hA2, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hA3, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'hA3, 0));
    tbl.push_back(mk(0, 1, 8'hB1, 0, 1, 0, 8'hA3, 0));
    tbl.push_back(mk(0, 1, 8'hB2, 0, 1, 0, 8'hA3, 1));
    tbl.push_back(mk(0, 1, 8'hB3, 0, 1, 1, 8'hB1, 2));
    tbl.push_back(mk(1, 1, 8'h55, 1, 0, 0, 8'hB1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'hB1, 0));
    tbl.push_back(mk(0, 1, 8'h66, 1, 1, 0, 8'hB1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'hB1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h66, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h66, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      f1 = tbl[i].fl; iv1 = tbl[i].iv; id1 = tbl[i].id; or1 = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), ir1, tbl[i].ir);
      chk($sformatf("v%0d out_valid", i), ov1, tbl[i].ov);
      chk($sformatf("v%0d out_data", i), od1, tbl[i].od);
      chk($sformatf("v%0d occupancy", i), oc1, tbl[i].oc);
      step();
    end
    f1 = 0; iv1 = 0; or1 = 0;

    iv0 = 1; id0 = 8'hC1; or0 = 0;
    @(negedge clk);
    chk("pass empty in_ready", ir0, 1);
    chk("pass empty out_valid", ov0, 0);
    chk("pass empty occupancy", oc0, 0);
    step();
    id0 = 8'hC2;
    @(negedge clk);
    chk("pass second in_ready", ir0, 1);
    step();
    id0 = 8'hC3;
    @(negedge clk);
    chk("pass full in_ready", ir0, 0);
    chk("pass full occupancy", oc0, 2);
    chk("pass full out_data", od0, 8'hC1);
    or0 = 1;
    #1;
    chk("pass full freed in_ready", ir0, 1);
    chk("pass full freed out_valid", ov0, 1);
    step();
    iv0 = 0; or0 = 0;
    @(negedge clk);
    chk("pass swap occupancy", oc0, 2);
    chk("pass swap out_data", od0, 8'hC2);
    step();
    or0 = 1;
    repeat (3) step();
    or0 = 0;

    iv1 = 1; id1 = 8'h01;
    step();
    id1 = 8'h02;
    step();
    iv1 = 0;
    @(negedge clk);
    chk("pre-reset occupancy", oc1, 2);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("post-reset out_valid", ov1, 0);
    chk("post-reset occupancy", oc1, 0);
    chk("post-reset in_ready", ir1, 1);
    chk("post-reset out_data", od1, 0);
    step();
    iv1 = 1; id1 = 8'h7E; or1 = 1;
    step();
    iv1 = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ov1) begin
        got = 1;
        chk("post-reset first beat", od1, 8'h7E);
      end
      step();
    end
    if (!got) chk("post-reset delivery timeout", 0, 1);
    repeat (3) step();

    acc1 = 0; acc0 = 0; del1 = 0; del0 = 0; cyc = 0;
    while ((del1 < 10000 || del0 < 10000) && cyc < 60000) begin
      iv1 = (acc1 < 10000) && ($urandom_range(3) != 0);
      iv0 = (acc0 < 10000) && ($urandom_range(3) != 0);
      id1 = 8'($urandom); id0 = 8'($urandom);
      or1 = $urandom_range(3) != 0;
      or0 = $urandom_range(3) != 0;
      @(negedge clk);
      chk("rand skid occupancy", oc1, q1.size());
      chk("rand pass occupancy", oc0, q0.size());
      if (ov1 && or1) begin
        if (q1.size() == 0) chk("rand skid spurious beat", 1, 0);
        else chk("rand skid data", od1, q1.pop_front());
        del1++;
      end
      if (ov0 && or0) begin
        if (q0.size() == 0) chk("rand pass spurious beat", 1, 0);
        else chk("rand pass data", od0, q0.pop_front());
        del0++;
      end
      if (iv1 && ir1) begin q1.push_back(id1); acc1++; end
      if (iv0 && ir0) begin q0.push_back(id0); acc0++; end
      step();
      cyc++;
    end
    if (del1 < 10000 || del0 < 10000) chk("rand delivery timeout", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
